// File: rtl/snes_port_sequencer_if.sv
// Frame push channel between the host-side frame loader and the port sequencer.
// The loader drives frame_data/frame_valid; a frame transfers when frame_valid && frame_ready.
interface snes_port_sequencer_if;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/snes_port_sequencer.sv
// SNES controller port sequencer: synchronises latch/clock from the console, pops one
// queued frame per latch and shifts it out MSB-first; replays the last frame on underrun.
//
// state   | meaning
// IDLE    | disabled or after reset, line held high
// LATCHED | frame loaded, line shows bit 15, waiting for latch to fall
// SHIFT   | advancing one bit per console clock rising edge
// DONE    | all 16 bits sent, line held low until the next latch
module snes_port_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        enable,
  input  logic                        snes_lat,
  input  logic                        snes_clk,
  output logic                        snes_data,
  snes_port_sequencer_if.slave        frame,
  output logic                        underrun,
  output logic [15:0]                 latch_count,
  output logic                        busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LATCHED, SHIFT, DONE} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] lat_sync, clk_sync;
  logic                   lat_hist, clk_hist;
  logic                   lat_s, clk_s;
  logic                   lat_rise, lat_fall, clk_rise;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, queue_empty;

  logic [15:0] shift, shift_d, load_val, last_frame;
  logic [4:0]  bit_cnt;
  logic        load, advance, snes_data_d;

  // Console clock idles high, so its synchroniser resets high to avoid a false edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lat_sync <= '0;
      clk_sync <= '1;
      lat_hist <= 1'b0;
      clk_hist <= 1'b1;
    end else begin
      lat_sync <= {lat_sync[SYNC_STAGES-2:0], snes_lat};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], snes_clk};
      lat_hist <= lat_s;
      clk_hist <= clk_s;
    end
  end

  assign lat_s    = lat_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign lat_rise = lat_s & ~lat_hist;
  assign lat_fall = ~lat_s & lat_hist;
  assign clk_rise = clk_s & ~clk_hist;

  assign queue_empty       = (count == '0);
  assign frame.frame_ready = (count != FULL);
  assign push              = frame.frame_valid && frame.frame_ready;
  assign pop               = load && !queue_empty;
  assign load_val          = queue_empty ? last_frame : mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= frame.frame_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d     = state;
    load        = 1'b0;
    advance     = 1'b0;
    shift_d     = shift;
    snes_data_d = 1'b1;
    if (!enable) begin
      state_d = IDLE;
    end else if (lat_rise) begin
      load    = 1'b1;
      state_d = LATCHED;
    end else begin
      case (state)
        LATCHED: if (lat_fall) state_d = SHIFT;
        SHIFT: if (clk_rise) begin
          advance = 1'b1;
          if (bit_cnt == 5'd15) state_d = DONE;
        end
        default: ;
      endcase
    end
    if (load)         shift_d = load_val;
    else if (advance) shift_d = {shift[14:0], 1'b0};
    case (state_d)
      LATCHED, SHIFT: snes_data_d = ~shift_d[15];
      DONE:           snes_data_d = 1'b0;
      default:        snes_data_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift       <= '0;
      bit_cnt     <= '0;
      last_frame  <= '0;
      latch_count <= '0;
      underrun    <= 1'b0;
      snes_data   <= 1'b1;
    end else begin
      shift     <= shift_d;
      snes_data <= snes_data_d;
      underrun  <= load && queue_empty;
      if (load) begin
        bit_cnt     <= '0;
        last_frame  <= load_val;
        latch_count <= latch_count + 16'd1;
      end else if (advance) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_snes_port_sequencer.sv
// Self-checking bench for snes_port_sequencer: table vectors, hand-written corner
// sequences and a randomized run against a queue-based model of the port.
module tb_snes_port_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic        snes_lat;
  logic        snes_clk;
  logic        snes_data;
  logic        underrun;
  logic [15:0] latch_count;
  logic        busy;

  snes_port_sequencer_if fif ();

  snes_port_sequencer #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .snes_lat    (snes_lat),
    .snes_clk    (snes_clk),
    .snes_data   (snes_data),
    .frame       (fif),
    .underrun    (underrun),
    .latch_count (latch_count),
    .busy        (busy)
  );

  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int under_seen = 0;

  logic [15:0] mq[$];
  logic [15:0] m_last;
  logic [15:0] m_cnt;

  typedef struct {
    bit          do_push;
    logic [15:0] push_val;
    bit          en;
    logic [15:0] exp_line;
    int          exp_under;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  always @(negedge sys_clk) if (underrun === 1'b1) under_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    bit ok;
    ok = 1'b0;
    fif.frame_data  = v;
    fif.frame_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (fif.frame_ready === 1'b1) ok = 1'b1;
      @(negedge sys_clk);
    end
    fif.frame_valid = 1'b0;
    check("push_accept", 32'(ok), 32'd1);
  endtask

  // Console-side poll: sample the line while latched, then at the end of each clock-high phase.
  task automatic poll(input int nclk, output logic [15:0] word, output logic done_lvl);
    word     = '1;
    done_lvl = 1'b1;
    snes_lat = 1'b1;
    repeat (12) @(negedge sys_clk);
    word[15] = snes_data;
    snes_lat = 1'b0;
    repeat (6) @(negedge sys_clk);
    for (int k = 1; k <= nclk; k++) begin
      snes_clk = 1'b0;
      repeat (6) @(negedge sys_clk);
      snes_clk = 1'b1;
      repeat (6) @(negedge sys_clk);
      if (k < 16) word[15-k] = snes_data;
      else        done_lvl   = snes_data;
    end
  endtask

  task automatic model_poll(input bit en);
    logic [15:0] w, f, e;
    logic        d;
    int          u0;
    int          exp_u;
    exp_u  = 0;
    enable = en;
    repeat (2) @(negedge sys_clk);
    u0 = under_seen;
    poll(16, w, d);
    if (en) begin
      if (mq.size() > 0) f = mq.pop_front();
      else begin
        f     = m_last;
        exp_u = 1;
      end
      m_last = f;
      m_cnt  = m_cnt + 16'd1;
      e      = ~f;
      check("line_word", 32'(w), 32'(e));
      check("done_level", 32'(d), 32'd0);
    end else begin
      check("line_disabled", 32'(w), 32'h0000FFFF);
      check("done_disabled", 32'(d), 32'd1);
    end
    check("underrun_pulses", under_seen - u0, exp_u);
    check("latch_count", 32'(latch_count), 32'(m_cnt));
    check("busy", 32'(busy), 32'(en));
    enable = 1'b1;
  endtask

  initial begin
    logic [15:0] w, e;
    logic        d;
    int          u0;
    logic [15:0] v;
    int          r;

    vecs[0] = '{1'b1, 16'h8001, 1'b1, 16'h7FFE, 0, 16'd1};
    vecs[1] = '{1'b1, 16'hA5A5, 1'b1, 16'h5A5A, 0, 16'd2};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h5A5A, 1, 16'd3};
    vecs[3] = '{1'b1, 16'h1234, 1'b0, 16'hFFFF, 0, 16'd3};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'hEDCB, 0, 16'd4};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 16'hEDCB, 1, 16'd5};

    sys_rst_n       = 1'b0;
    enable          = 1'b1;
    snes_lat        = 1'b0;
    snes_clk        = 1'b1;
    fif.frame_valid = 1'b0;
    fif.frame_data  = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_data", 32'(snes_data), 32'd1);
    check("rst_ready", 32'(fif.frame_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_count", 32'(latch_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_push) push(vecs[i].push_val);
      enable = vecs[i].en;
      repeat (2) @(negedge sys_clk);
      u0 = under_seen;
      poll(16, w, d);
      check($sformatf("vec%0d_line", i), 32'(w), 32'(vecs[i].exp_line));
      check($sformatf("vec%0d_done", i), 32'(d), vecs[i].en ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_underrun", i), under_seen - u0, vecs[i].exp_under);
      check($sformatf("vec%0d_count", i), 32'(latch_count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].en));
      enable = 1'b1;
    end
    mq.delete();
    m_last = 16'h1234;
    m_cnt  = 16'd5;

    // Queue full: fifth frame is held until a latch frees a slot.
    for (int i = 0; i < 4; i++) begin
      v = 16'h1100 + 16'(i);
      push(v);
      mq.push_back(v);
      check($sformatf("ready_after_push%0d", i + 1), 32'(fif.frame_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    fif.frame_data  = 16'h5505;
    fif.frame_valid = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("ready_held", 32'(fif.frame_ready), 32'd0);
    model_poll(1'b1);
    fif.frame_valid = 1'b0;
    mq.push_back(16'h5505);
    check("ready_refilled", 32'(fif.frame_ready), 32'd0);
    for (int i = 0; i < 4; i++) model_poll(1'b1);
    check("ready_drained", 32'(fif.frame_ready), 32'd1);

    // Relatch after 7 clocks aborts 0x1234 and restarts at bit 15 of 0xFFFF.
    push(16'h1234);
    push(16'hFFFF);
    mq.push_back(16'h1234);
    mq.push_back(16'hFFFF);
    poll(7, w, d);
    e = w;
    check("partial_bits", 32'(e[15:8]), 32'h000000ED);
    void'(mq.pop_front());
    m_last = 16'h1234;
    m_cnt  = m_cnt + 16'd1;
    model_poll(1'b1);

    // Reset after clock 8 of a frame.
    push(16'h0F0F);
    poll(8, w, d);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_data", 32'(snes_data), 32'd1);
    check("midrst_ready", 32'(fif.frame_ready), 32'd1);
    check("midrst_underrun", 32'(underrun), 32'd0);
    check("midrst_count", 32'(latch_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    mq.delete();
    m_last = 16'h0000;
    m_cnt  = 16'd0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    model_poll(1'b1);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        if (mq.size() < 4) begin
          v = 16'($urandom);
          push(v);
          mq.push_back(v);
        end else begin
          check("rnd_ready_full", 32'(fif.frame_ready), 32'd0);
        end
      end else if (r == 4) begin
        model_poll(1'b0);
      end else begin
        model_poll(1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snes_port_sequencer.md
# snes_port_sequencer

Console-facing sequencer for one SNES controller port, running on the 48 MHz system clock. It synchronises the console's latch and clock lines and pops one 16-bit input frame per latch from a small frame queue. It serialises that frame MSB-first onto the port data line. It sits between the host-side frame loader (valid/ready push) and the controller connector, and replays the previous frame when the queue is empty.

## Interface
- FIFO_DEPTH, 4: frame queue entries (power of two, ≥2).
- SYNC_STAGES, 2: flip-flop stages on snes_lat and snes_clk (≥2).
- sys_clk  in  1  system clock, 48 MHz; all logic on rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low).
- enable  in  1  port enable; low forces IDLE.
- snes_lat  in  1  console latch, asynchronous, active-high (~12 us pulse, ~16.67 ms period).
- snes_clk  in  1  console clock, asynchronous, idle high, 16 pulses of 6 us low / 6 us high after latch.
- snes_data  out  1  port data line level; 0 = button pressed.
- frame_data  in  16  next frame; bit 15 is sent first; 1 = pressed.
- frame_valid  in  1  frame_data valid.
- frame_ready  out  1  queue not full; push when frame_valid && frame_ready.
- underrun  out  1  one-cycle pulse: latch accepted with queue empty.
- latch_count  out  16  accepted latches, wraps.
- busy  out  1  FSM not IDLE.

## Operation
- Sync: snes_lat/snes_clk pass through SYNC_STAGES flops, plus one history flop for edge detect; lat_rise, lat_fall, clk_rise are single-cycle strobes.
- Queue: FIFO_DEPTH x 16 circular buffer; read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH. frame_ready = (count != FIFO_DEPTH). No bypass: a frame pushed in the same cycle as lat_rise on an empty queue is not used for that latch.
- last_frame register holds the frame most recently loaded; reset 0x0000.
- FSM states: IDLE, LATCHED, SHIFT, DONE.
- Any state, enable=1, lat_rise: load shift register from queue head (pop) if count>0, else from last_frame with an underrun pulse; last_frame <= loaded value; bit_cnt <= 0; latch_count += 1; go LATCHED. A relatch mid-SHIFT aborts the current frame and counts as a new poll.
- LATCHED: snes_data = ~shift[15]; clk_rise ignored; lat_fall -> SHIFT.
- SHIFT: on clk_rise: shift left by 1, bit_cnt += 1; snes_data = ~shift[15]. When the 16th clk_rise is seen (bit_cnt 15 -> 16) go DONE.
- DONE: snes_data = 0 (reads as 1s, standard-pad behaviour); further clk_rise ignored; wait for next lat_rise.
- IDLE: snes_data = 1.
- enable=0: next cycle FSM = IDLE, snes_data = 1, lat_rise ignored (no pop, no count, no underrun); queue contents and pushes unaffected.
- Simultaneous push and pop with 0<count<FIFO_DEPTH: count unchanged, both pointers advance.

## Timing
- Reset values: snes_data=1, frame_ready=1, underrun=0, latch_count=0, busy=0, FSM IDLE, queue empty, last_frame=0x0000. Asserting sys_rst_n mid-frame returns to these values immediately; the queue is flushed.
- Latency: pin edge to strobe is SYNC_STAGES+1 cycles (uncertainty ±1 cycle). snes_data update is registered, 1 cycle after the strobe. Total for SYNC_STAGES=2 is 4 cycles (~83 ns), well inside the 6 us half-period.
- underrun pulse and the latch_count increment are in the same cycle as the snes_data load.
- frame_ready reflects count registered in the previous cycle; it goes low the cycle after the push that fills the queue.
- latch_count wraps 0xFFFF -> 0x0000.
- busy = 1 from the cycle after lat_rise until the FSM returns to IDLE (only via enable=0 or reset); DONE counts as busy.

## Test plan
- Reset, push 0x8001, one 12 us latch plus 16 clocks -> snes_data low while latched (bit 15). Data high for the 14 middle bits, low on bit 0, low (DONE) after clock 16. latch_count=1.
- Queue empty, push 0xA5A5 then latch twice -> both polls emit 0xA5A5 inverted on the line; one underrun pulse, on the second latch only.
- Push 5 frames with FIFO_DEPTH=4 -> frame_ready low after the 4th push, and the 5th is held until the first latch pops. Latches return frames 1-4 in order.
- Relatch after 7 clocks with 0x1234 then 0xFFFF queued -> the second latch restarts at bit 15 of 0xFFFF (snes_data=0). bit_cnt resets and latch_count increments.
- enable=0 during a latch -> snes_data stays 1, no pop, latch_count unchanged. Re-enable plus latch -> the held frame is emitted.
- Assert sys_rst_n after clock 8 -> outputs at reset values within the same cycle, queue empty. The next latch emits 0x0000 (snes_data=1 for all 16 bits) with an underrun pulse.
